test_hu_div_24u_8u_seq: RTL and testbench

Iterative unsigned divider, 24-bit dividend by 8-bit divisor, producing a 16-bit quotient and 8-bit remainder. It is the inverse of the 16×8→24 unsigned multiplier used in the Hu-moment datapath. The divider normalises accumulated moment sums back into 16-bit range, and sits between the moment accumulators and the invariant computation. It performs restoring division one quotient bit per enabled cycle, with a start/done handshake and the same `ce` clock-enable gating as the surrounding HLS pipeline.

---
 rtl/test_hu_div_pkg.sv | 20 ++
 rtl/test_hu_div_24u_8u_seq_step.sv | 30 +++
 rtl/test_hu_div_24u_8u_seq.sv | 160 ++++++++++++++++
 tb/tb_test_hu_div_24u_8u_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_hu_div_pkg.sv
// Shared widths, state encoding and saturation constant for the Hu-moment
// 24u/8u sequential divider.
package test_hu_div_pkg;

  localparam int DIV_DIVIDEND_W = 24;
  localparam int DIV_DIVISOR_W  = 8;
  localparam int DIV_QUOT_W     = DIV_DIVIDEND_W - DIV_DIVISOR_W;

  // Quotient value reported on divide-by-zero, overflow or rounding saturation.
  localparam logic [DIV_QUOT_W-1:0] DIV_QUOT_SAT = 16'hFFFF;

  // ST_ROUND is only visited when TEST_HU_DIV_ROUND_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/test_hu_div_24u_8u_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module test_hu_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_pr,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_pr,
  output logic         o_pr_carry,
  output logic         o_qbit
);

  logic [W:0]   w_shifted;
  logic [W+1:0] w_diff;
  logic [W:0]   w_sel;

  // The trial difference carries one extra bit so its sign is the borrow.
  // o_pr_carry flags a remainder that no longer fits in W bits, which can
  // only happen when the operands were already out of range.
  always_comb begin
    w_shifted  = {i_pr, i_bit};
    w_diff     = {1'b0, w_shifted} - {2'b00, i_divisor};
    o_qbit     = ~w_diff[W+1];
    w_sel      = o_qbit ? w_diff[W:0] : w_shifted;
    o_pr       = w_sel[W-1:0];
    o_pr_carry = w_sel[W];
  end

endmodule

// File: rtl/test_hu_div_24u_8u_seq.sv
// Iterative unsigned 24/8 restoring divider, one quotient bit per enabled
// cycle, with start/done handshake and ce gating.
// Optional macro TEST_HU_DIV_ROUND_EN adds a one-cycle round-half-up stage.
module test_hu_div_24u_8u_seq
  import test_hu_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W,
  parameter int QUOT_W     = DIVIDEND_W - DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  ready,
  output logic                  done,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(QUOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUOT_W - 1);

  div_state_t           r_state;
  logic [DIVISOR_W-1:0] r_pr;
  logic [QUOT_W-1:0]    r_q;
  logic [DIVISOR_W-1:0] r_divisor;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic [QUOT_W-1:0]    r_quot;
  logic [DIVISOR_W-1:0] r_rem;
  logic                 r_ovf;

  logic [DIVISOR_W-1:0] w_pr_next;
  logic                 w_pr_carry;
  logic                 w_qbit;
  logic [QUOT_W-1:0]    w_q_next;
  logic                 w_err_in;
  logic                 w_err_next;
`ifdef TEST_HU_DIV_ROUND_EN
  logic                 w_round_up;
`endif

  test_hu_div_step #(
    .W (DIVISOR_W)
  ) u_step (
    .i_pr       (r_pr),
    .i_bit      (r_q[QUOT_W-1]),
    .i_divisor  (r_divisor),
    .o_pr       (w_pr_next),
    .o_pr_carry (w_pr_carry),
    .o_qbit     (w_qbit)
  );

  // Error detection at start (upper dividend byte must be below the divisor)
  // plus the shifted quotient and rounding decision for the datapath.
  always_comb begin
    w_q_next   = {r_q[QUOT_W-2:0], w_qbit};
    w_err_in   = (din1 == '0) || (din0[DIVIDEND_W-1 -: DIVISOR_W] >= din1);
    w_err_next = r_err | w_pr_carry;
`ifdef TEST_HU_DIV_ROUND_EN
    w_round_up = ({r_pr, 1'b0} >= {1'b0, r_divisor});
`endif
  end

  // Control FSM and datapath registers; everything advances only when ce=1,
  // while reset clears the block regardless of ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pr      <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_ovf     <= 1'b0;
    end else if (ce) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_divisor <= din1;
            r_err     <= w_err_in;
            r_pr      <= din0[DIVIDEND_W-1 -: DIVISOR_W];
            r_q       <= din0[QUOT_W-1:0];
            r_cnt     <= '0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_pr  <= w_pr_next;
          r_q   <= w_q_next;
          r_err <= w_err_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
`ifdef TEST_HU_DIV_ROUND_EN
            r_state <= ST_ROUND;
`else
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            if (w_err_next) begin
              r_quot <= DIV_QUOT_SAT;
              r_rem  <= '0;
              r_ovf  <= 1'b1;
            end else begin
              r_quot <= w_q_next;
              r_rem  <= w_pr_next;
              r_ovf  <= 1'b0;
            end
`endif
          end
        end
`ifdef TEST_HU_DIV_ROUND_EN
        ST_ROUND: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
          if (r_err) begin
            r_quot <= DIV_QUOT_SAT;
            r_rem  <= '0;
            r_ovf  <= 1'b1;
          end else begin
            r_rem <= r_pr;
            if (w_round_up && (r_q == DIV_QUOT_SAT)) begin
              r_quot <= DIV_QUOT_SAT;
              r_ovf  <= 1'b1;
            end else if (w_round_up) begin
              r_quot <= r_q + 1'b1;
              r_ovf  <= 1'b0;
            end else begin
              r_quot <= r_q;
              r_ovf  <= 1'b0;
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Only ready is combinational; it lets a new start land in the done cycle.
  always_comb begin
    ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
    done  = r_done;
    quot  = r_quot;
    rem   = r_rem;
    ovf   = r_ovf;
  end

endmodule

// File: tb/tb_test_hu_div_24u_8u_seq.sv
// Self-checking bench for the 24u/8u sequential divider. Expected results
// come from a behavioural division model and are queued when each start is
// driven, then popped when done is seen.
module tb_test_hu_div_24u_8u_seq;

`ifdef TEST_HU_DIV_ROUND_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        o;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        start;
  logic [23:0] din0;
  logic [7:0]  din1;
  logic        ready;
  logic        done;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        ovf;

  int   nVectors;
  int   nMiscompares;
  exp_t sb[$];
  exp_t lastExp;

  test_hu_div_24u_8u_seq dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .quot  (quot),
    .rem   (rem),
    .ovf   (ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: plain integer division with the error and
  // optional rounding rules layered on top.
  function automatic exp_t model(input logic [23:0] a, input logic [7:0] b);
    exp_t        e;
    int unsigned ua;
    int unsigned ub;
    int unsigned qq;
    int unsigned rr;
    ua = a;
    ub = b;
    if (ub == 0 || (ua >> 16) >= ub) begin
      e.q = 16'hFFFF;
      e.r = 8'h00;
      e.o = 1'b1;
      return e;
    end
    qq  = ua / ub;
    rr  = ua % ub;
    e.q = qq[15:0];
    e.r = rr[7:0];
    e.o = 1'b0;
`ifdef TEST_HU_DIV_ROUND_EN
    if (2 * rr >= ub) begin
      if (qq == 32'h0000FFFF) e.o = 1'b1;
      else e.q = 16'(qq + 1);
    end
`endif
    return e;
  endfunction

  // Drive one start pulse (called on a falling edge, returns on the next
  // falling edge) and optionally queue the expected result.
  task automatic applyStimulus(input logic [23:0] a, input logic [7:0] b, input bit record);
    if (record) sb.push_back(model(a, b));
    ce    = 1'b1;
    start = 1'b1;
    din0  = a;
    din1  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, counting ce-high edges; optionally inject a stray start
  // at iteration injectAt. Returns latency in enabled cycles incl. the start edge.
  task automatic waitDone(input bit randCe, input int injectAt, output int lat, output bit timedOut);
    int edges;
    edges    = 0;
    timedOut = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == injectAt) begin
        ce    = 1'b1;
        start = 1'b1;
        din0  = 24'd5;
        din1  = 8'd1;
      end else begin
        start = 1'b0;
        ce    = randCe ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (ce) edges++;
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    start = 1'b0;
    lat   = edges + 1;
  endtask

  // Reset with ce low must still clear every output.
  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (2) @(negedge clk);
    nVectors++;
    if ({ready, done, quot, rem, ovf} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      nMiscompares++;
      $display("[TB] FAIL reset_state got rdy=%b done=%b q=%h r=%h o=%b want 1 0 0000 00 0",
               ready, done, quot, rem, ovf);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Directed arithmetic cases, run back to back with ce held high.
  task automatic test_arith();
    logic [23:0] as [5] = '{24'd1000, 24'h00FFFF, 24'hFFFFFF, 24'h123456, 24'd65535};
    logic [7:0]  bs [5] = '{8'd7, 8'd1, 8'hFF, 8'd0, 8'd255};
    int   lat;
    bit   to;
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(as[k], bs[k], 1'b1);
      waitDone(1'b0, -1, lat, to);
      e = sb.pop_front();
      lastExp = e;
      nVectors++;
      if (to || lat != LAT) begin
        nMiscompares++;
        $display("[TB] FAIL arith%0d_latency got %0d (timeout=%b) want %0d", k, lat, to, LAT);
      end
      nVectors++;
      if ({quot, rem, ovf} !== {e.q, e.r, e.o}) begin
        nMiscompares++;
        $display("[TB] FAIL arith%0d_result got q=%h r=%h o=%b want q=%h r=%h o=%b",
                 k, quot, rem, ovf, e.q, e.r, e.o);
      end
    end
  endtask

  // Random ce during 1000/8, then a second start in the done cycle.
  task automatic test_ce_stall();
    logic [23:0] as [2] = '{24'd1000, 24'd50000};
    logic [7:0]  bs [2] = '{8'd8, 8'd200};
    int   lat;
    bit   to;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(as[k], bs[k], 1'b1);
      waitDone(1'b1, -1, lat, to);
      e = sb.pop_front();
      lastExp = e;
      nVectors++;
      if (to || lat != LAT) begin
        nMiscompares++;
        $display("[TB] FAIL ce_stall%0d_latency got %0d (timeout=%b) want %0d", k, lat, to, LAT);
      end
      nVectors++;
      if ({quot, rem, ovf} !== {e.q, e.r, e.o}) begin
        nMiscompares++;
        $display("[TB] FAIL ce_stall%0d_result got q=%h r=%h o=%b want q=%h r=%h o=%b",
                 k, quot, rem, ovf, e.q, e.r, e.o);
      end
    end
  endtask

  // done stretches while ce is low, then clears after one enabled cycle
  // while results hold.
  task automatic test_done_pulse();
    start = 1'b0;
    ce    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nVectors++;
      if (done !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL done_stretch got %b want 1", done);
      end
    end
    ce = 1'b1;
    @(negedge clk);
    nVectors++;
    if ({done, ready, quot, rem, ovf} !== {1'b0, 1'b1, lastExp.q, lastExp.r, lastExp.o}) begin
      nMiscompares++;
      $display("[TB] FAIL done_clear got done=%b rdy=%b q=%h r=%h o=%b want 0 1 %h %h %b",
               done, ready, quot, rem, ovf, lastExp.q, lastExp.r, lastExp.o);
    end
  endtask

  // A start raised mid-run must not disturb the running division.
  task automatic test_start_ignored();
    int   lat;
    bit   to;
    exp_t e;
    applyStimulus(24'd1000, 8'd7, 1'b1);
    waitDone(1'b0, 5, lat, to);
    e = sb.pop_front();
    lastExp = e;
    nVectors++;
    if (to || lat != LAT) begin
      nMiscompares++;
      $display("[TB] FAIL start_ignored_latency got %0d (timeout=%b) want %0d", lat, to, LAT);
    end
    nVectors++;
    if ({quot, rem, ovf} !== {e.q, e.r, e.o}) begin
      nMiscompares++;
      $display("[TB] FAIL start_ignored_result got q=%h r=%h o=%b want q=%h r=%h o=%b",
               quot, rem, ovf, e.q, e.r, e.o);
    end
  endtask

  // Random operand stream issued back to back with random ce.
  task automatic test_back_to_back();
    int          lat;
    bit          to;
    exp_t        e;
    logic [23:0] a;
    logic [7:0]  b;
    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom_range(0, 32'hFFFFFF));
      if (k % 2 == 0) a = a & 24'h03FFFF;
      b = 8'($urandom_range(0, 255));
      applyStimulus(a, b, 1'b1);
      waitDone(1'b1, -1, lat, to);
      e = sb.pop_front();
      lastExp = e;
      nVectors++;
      if (to || lat != LAT) begin
        nMiscompares++;
        $display("[TB] FAIL b2b%0d_latency got %0d (timeout=%b) want %0d", k, lat, to, LAT);
      end
      nVectors++;
      if ({quot, rem, ovf} !== {e.q, e.r, e.o}) begin
        nMiscompares++;
        $display("[TB] FAIL b2b%0d_result a=%h b=%h got q=%h r=%h o=%b want q=%h r=%h o=%b",
                 k, a, b, quot, rem, ovf, e.q, e.r, e.o);
      end
    end
  endtask

  // Reset after eight RUN steps aborts the division with no done afterwards.
  task automatic test_reset_mid_run();
    int sawDone;
    applyStimulus(24'd1000, 8'd7, 1'b0);
    repeat (8) @(negedge clk);
    nVectors++;
    if (ready !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL run_ready got %b want 0", ready);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nVectors++;
    if ({ready, done, quot, rem, ovf} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      nMiscompares++;
      $display("[TB] FAIL abort_state got rdy=%b done=%b q=%h r=%h o=%b want 1 0 0000 00 0",
               ready, done, quot, rem, ovf);
    end
    sawDone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    nVectors++;
    if (sawDone != 0) begin
      nMiscompares++;
      $display("[TB] FAIL abort_no_done got %0d done cycles want 0", sawDone);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    test_reset();
    test_arith();
    test_ce_stall();
    test_done_pulse();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
